// File: rtl/step_pulse_gen_pkg.sv
// Shared types and default constants for the step pulse generator and its siblings.
package step_pulse_gen_pkg;

   localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
   localparam int unsigned CNT_W_DEF           = 16;
   localparam int unsigned STEP_W_DEF          = 16;
   localparam int unsigned AUTO_PERIOD_DEF     = 1000;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_e;

endpackage

// File: rtl/step_pulse_gen_if.sv
// Stepping-source / step-enable bundle between the board input side and the core.
// auto_mode exists only when AUTO_STEP_EN is defined.
interface step_pulse_gen_if #(
   parameter int unsigned STEP_W = step_pulse_gen_pkg::STEP_W_DEF
);
   logic              step_in;
`ifdef AUTO_STEP_EN
   logic              auto_mode;
`endif
   logic              step_pulse;
   logic [STEP_W-1:0] step_count;
   logic              busy;

`ifdef AUTO_STEP_EN
   modport master (output step_in, output auto_mode,
                   input  step_pulse, input step_count, input busy);
   modport slave  (input  step_in, input  auto_mode,
                   output step_pulse, output step_count, output busy);
`else
   modport master (output step_in,
                   input  step_pulse, input step_count, input busy);
   modport slave  (input  step_in,
                   output step_pulse, output step_count, output busy);
`endif
endinterface

// File: rtl/step_pulse_gen_sync_2ff.sv
// Generic two-flop synchroniser, async active-high reset to 0; reused for board inputs.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH-1:0] s1_q;
   logic [WIDTH-1:0] s2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;
endmodule

// File: rtl/step_pulse_gen.sv
// Debounced single-cycle step enable for the KGP-miniRISC core, plus a wrapping step count.
// Optional AUTO_STEP_EN adds auto_mode: internal periodic stepping every AUTO_PERIOD cycles.
module step_pulse_gen
   import step_pulse_gen_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned CNT_W           = CNT_W_DEF,
   parameter int unsigned STEP_W          = STEP_W_DEF
`ifdef AUTO_STEP_EN
   ,
   parameter int unsigned AUTO_PERIOD     = AUTO_PERIOD_DEF
`endif
) (
   input  logic            clk,
   input  logic            rst,
   step_pulse_gen_if.slave pulse_if
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [STEP_W-1:0] count_q, count_d;
   logic              pulse_q, pulse_d;
   logic              busy_q,  busy_d;
   logic              s2_c;
   logic              auto_c;

   sync_2ff #(.WIDTH(1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (pulse_if.step_in),
      .q_o (s2_c)
   );

`ifdef AUTO_STEP_EN
   // Period counter runs 1..AUTO_PERIOD while auto_mode is high, so the first
   // pulse lands AUTO_PERIOD cycles after auto_mode is first sampled.
   localparam int unsigned PER_W = $clog2(AUTO_PERIOD + 1);
   logic [PER_W-1:0] per_q, per_d;

   assign auto_c = pulse_if.auto_mode;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) per_q <= '0;
      else     per_q <= per_d;
   end
`else
   assign auto_c = 1'b0;
`endif

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         count_q <= '0;
         pulse_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         count_q <= count_d;
         pulse_q <= pulse_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:         if (s2_c) state_d = PRESS_WAIT;
         PRESS_WAIT:   if (!s2_c) state_d = IDLE;
                       else if (cnt_q == CNT_LAST) state_d = HELD;
         HELD:         if (!s2_c) state_d = RELEASE_WAIT;
         RELEASE_WAIT: if (s2_c) state_d = HELD;
                       else if (cnt_q == CNT_LAST) state_d = IDLE;
         default:      state_d = IDLE;
      endcase
      if (auto_c) state_d = IDLE;
   end

   // Counter, pulse, step count and busy
   always_comb begin
      cnt_d   = '0;
      pulse_d = 1'b0;
      busy_d  = (state_q != IDLE);
      case (state_q)
         PRESS_WAIT: begin
            if (s2_c) begin
               if (cnt_q == CNT_LAST) pulse_d = 1'b1;
               else                   cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         RELEASE_WAIT: begin
            if (!s2_c && (cnt_q != CNT_LAST)) cnt_d = cnt_q + CNT_W'(1);
         end
         default: ;
      endcase
`ifdef AUTO_STEP_EN
      per_d = '0;
      if (auto_c) begin
         cnt_d   = '0;
         pulse_d = (per_q == PER_W'(AUTO_PERIOD));
         per_d   = pulse_d ? PER_W'(1) : per_q + PER_W'(1);
      end
`endif
      count_d = pulse_d ? count_q + STEP_W'(1) : count_q;
   end

   assign pulse_if.step_pulse = pulse_q;
   assign pulse_if.step_count = count_q;
   assign pulse_if.busy       = busy_q;
endmodule
